// File: rtl/mem_access_unit.sv
// Load/store unit: turns a CPU memory-stage access into a word-addressed
// req/ack transaction with byte enables and returns formatted load data.
module mem_access_unit #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_store,
   input  logic [2:0]            mem_control,
   input  logic [31:0]           addr,
   input  logic [31:0]           store_data,
   output logic [31:0]           load_data,
   output logic                  done,
   output logic                  err,
   output logic                  busy,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [31:0]           dmem_wdata,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_ack
);

   localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic [2:0]              f3_q, f3_next;
   logic [1:0]              lane_q, lane_next;
   logic [31:0]             load_next, wdata_next, wdata_c, fmt_c;
   logic                    done_next, err_next, busy_next, req_next, we_next;
   logic [ADDR_WIDTH-1:0]   addr_next;
   logic [3:0]              be_next, be_c;
   logic                    illegal_c, misaligned_c;
   logic [7:0]              byte_c;
   logic [15:0]             half_c;

   // Address bits above the word-address window are intentionally ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

   // Legality, byte-enable and lane-replicated write-data for the incoming access.
   always_comb begin
      illegal_c    = is_store ? (mem_control[2] || (mem_control[1:0] == 2'b11))
                              : ((mem_control == 3'b011) || (mem_control[2:1] == 2'b11));
      misaligned_c = ((mem_control[1:0] == 2'b01) && addr[0]) ||
                     ((mem_control[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      case (mem_control[1:0])
         2'b00:   begin be_c = 4'(4'b0001 << addr[1:0]); wdata_c = {4{store_data[7:0]}};  end
         2'b01:   begin be_c = 4'(4'b0011 << addr[1:0]); wdata_c = {2{store_data[15:0]}}; end
         default: begin be_c = 4'b1111;                  wdata_c = store_data;            end
      endcase
   end

   // Extract and extend the addressed lane of the returned read word.
   always_comb begin
      byte_c = dmem_rdata[8*lane_q +: 8];
      half_c = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'b000:  fmt_c = {{24{byte_c[7]}}, byte_c};
         3'b100:  fmt_c = {24'b0, byte_c};
         3'b001:  fmt_c = {{16{half_c[15]}}, half_c};
         3'b101:  fmt_c = {16'b0, half_c};
         default: fmt_c = dmem_rdata;
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      f3_next    = f3_q;
      lane_next  = lane_q;
      load_next  = '0;
      done_next  = 1'b0;
      err_next   = 1'b0;
      req_next   = dmem_req;
      we_next    = dmem_we;
      addr_next  = dmem_addr;
      be_next    = dmem_be;
      wdata_next = dmem_wdata;
      case (state)
         IDLE: begin
            if (start) begin
               f3_next   = mem_control;
               lane_next = addr[1:0];
               cnt_next  = '0;
               if (illegal_c || misaligned_c) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  err_next   = 1'b1;
               end else begin
                  state_next = ACCESS;
                  req_next   = 1'b1;
                  we_next    = is_store;
                  addr_next  = addr[ADDR_WIDTH+1:2];
                  be_next    = be_c;
                  wdata_next = is_store ? wdata_c : 32'h0;
               end
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               state_next = DONE;
               req_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               load_next  = dmem_we ? 32'h0 : fmt_c;
            end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TMO_LAST))) begin
               state_next = DONE;
               req_next   = 1'b0;
               we_next    = 1'b0;
               done_next  = 1'b1;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         lane_q     <= '0;
         load_data  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         f3_q       <= f3_next;
         lane_q     <= lane_next;
         load_data  <= load_next;
         done       <= done_next;
         err        <= err_next;
         busy       <= busy_next;
         dmem_req   <= req_next;
         dmem_we    <= we_next;
         dmem_addr  <= addr_next;
         dmem_be    <= be_next;
         dmem_wdata <= wdata_next;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever done is presented.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst, start, is_store, dmem_ack;
   logic [2:0]  mem_control;
   logic [31:0] addr, store_data, dmem_rdata;
   logic [31:0] load_data, dmem_wdata;
   logic        done, err, busy, dmem_req, dmem_we;
   logic [9:0]  dmem_addr;
   logic [3:0]  dmem_be;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] ld;
      logic        err;
   } resp_t;

   resp_t sb_q[$];
   resp_t mon_e;
   logic  done_d = 1'b0;

   mem_access_unit #(.ADDR_WIDTH(10), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store),
      .mem_control(mem_control), .addr(addr), .store_data(store_data),
      .load_data(load_data), .done(done), .err(err), .busy(busy),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expected response.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         done_d = 1'b0;
      end else begin
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 with load_data=%h err=%b, expected no done", load_data, err);
            end else begin
               mon_e = sb_q.pop_front();
               check("mon.load_data", load_data, mon_e.ld);
               check("mon.err", 32'(err), 32'(mon_e.err));
            end
            check("mon.done_width", 32'(done_d), 32'd0);
         end
         done_d = done;
      end
   end

   // One access: drive start in an IDLE cycle, answer the request, wait for return to IDLE.
   task automatic do_access(input string nm, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                            input int ack_after, input bit exp_req, input logic [9:0] e_addr,
                            input logic [3:0] e_be, input logic [31:0] e_wd, input int e_hi,
                            input bit e_err, input logic [31:0] e_ld);
      int hi;
      int guard;
      @(negedge clk);
      is_store    = st;
      mem_control = f3;
      addr        = a;
      store_data  = sd;
      start       = 1'b1;
      sb_q.push_back('{e_ld, e_err});
      @(posedge clk);
      #1 start = 1'b0;
      if (exp_req) begin
         check({nm, ".req"},   32'(dmem_req), 32'd1);
         check({nm, ".we"},    32'(dmem_we), 32'(st));
         check({nm, ".addr"},  32'(dmem_addr), 32'(e_addr));
         check({nm, ".be"},    32'(dmem_be), 32'(e_be));
         check({nm, ".wdata"}, dmem_wdata, e_wd);
         hi    = 0;
         guard = 0;
         while (dmem_req === 1'b1 && guard < 200) begin
            @(negedge clk);
            if (hi == ack_after) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rd;
            end
            hi++;
            guard++;
            @(posedge clk);
            #1 dmem_ack = 1'b0;
         end
         check({nm, ".req_cycles"}, 32'(hi), 32'(e_hi));
      end else begin
         check({nm, ".no_req"}, 32'(dmem_req), 32'd0);
      end
      check({nm, ".done"}, 32'(done), 32'd1);
      @(posedge clk);
      #1 check({nm, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; start = 1'b0; is_store = 1'b0; mem_control = 3'b000;
      addr = '0; store_data = '0; dmem_rdata = '0; dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.done", 32'(done), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.req",  32'(dmem_req), 32'd0);
      check("rst.outs", {load_data | dmem_wdata}, 32'd0);
      check("rst.misc", 32'({err, dmem_we, dmem_addr, dmem_be}), 32'd0);
      @(negedge clk) rst = 1'b1;

      do_access("sw",   1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 0, 1, 10'd2, 4'b1111, 32'hDEAD_BEEF, 1, 0, 32'h0);
      do_access("lb",   0, 3'b000, 32'h0000_0003, 32'h0, 32'h80AB_CDEF, 0, 1, 10'd0, 4'b1000, 32'h0, 1, 0, 32'hFFFF_FF80);
      do_access("lbu",  0, 3'b100, 32'h0000_0003, 32'h0, 32'h80AB_CDEF, 0, 1, 10'd0, 4'b1000, 32'h0, 1, 0, 32'h0000_0080);
      do_access("lh",   0, 3'b001, 32'h0000_0002, 32'h0, 32'h80AB_CDEF, 1, 1, 10'd0, 4'b1100, 32'h0, 2, 0, 32'hFFFF_80AB);
      do_access("lhu",  0, 3'b101, 32'h0000_0002, 32'h0, 32'h80AB_CDEF, 0, 1, 10'd0, 4'b1100, 32'h0, 1, 0, 32'h0000_80AB);
      do_access("lw",   0, 3'b010, 32'h0000_0004, 32'h0, 32'h1234_5678, 2, 1, 10'd1, 4'b1111, 32'h0, 3, 0, 32'h1234_5678);
      do_access("sb",   1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 32'h0, 0, 1, 10'd1, 4'b0010, 32'hA5A5_A5A5, 1, 0, 32'h0);
      do_access("sh",   1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h0, 0, 1, 10'd1, 4'b1100, 32'hBEEF_BEEF, 1, 0, 32'h0);
      do_access("lbhi", 0, 3'b000, 32'hFFFF_F004, 32'h0, 32'h0000_007F, 0, 1, 10'd1, 4'b0001, 32'h0, 1, 0, 32'h0000_007F);
      do_access("lw_mis", 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 10'd0, 4'b0, 32'h0, 0, 1, 32'h0);
      do_access("s_ill",  1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 10'd0, 4'b0, 32'h0, 0, 1, 32'h0);
      do_access("lh_mis", 0, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 0, 0, 10'd0, 4'b0, 32'h0, 0, 1, 32'h0);
      do_access("l_ill",  0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0, 10'd0, 4'b0, 32'h0, 0, 1, 32'h0);
      do_access("tmo",    0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, -1, 1, 10'd4, 4'b1111, 32'h0, 16, 1, 32'h0);
      do_access("ack5",   0, 3'b010, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 5, 1, 10'd4, 4'b1111, 32'h0, 6, 0, 32'hCAFE_F00D);

      // Stray ack while idle must not complete anything.
      @(negedge clk) dmem_ack = 1'b1;
      @(posedge clk);
      #1 dmem_ack = 1'b0;
      check("idle_ack.done", 32'(done), 32'd0);
      check("idle_ack.busy", 32'(busy), 32'd0);

      // Reset during ACCESS aborts the transfer; a late ack is ignored.
      @(negedge clk);
      is_store = 1'b0; mem_control = 3'b010; addr = 32'h0000_0020; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("abort.req_before", 32'(dmem_req), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort.req",  32'(dmem_req), 32'd0);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.outs", {load_data | dmem_wdata}, 32'd0);
      check("abort.misc", 32'({err, dmem_we, dmem_addr, dmem_be}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
      @(posedge clk);
      #1 dmem_ack = 1'b0;
      check("late_ack.done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 check("late_ack.busy", 32'(busy), 32'd0);

      // Back-to-back after recovery.
      do_access("b2b_a", 0, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_F100, 0, 1, 10'd0, 4'b0010, 32'h0, 1, 0, 32'hFFFF_FFF1);
      do_access("b2b_b", 0, 3'b101, 32'h0000_0000, 32'h0, 32'h0000_9001, 0, 1, 10'd0, 4'b0011, 32'h0, 1, 0, 32'h0000_9001);

      repeat (2) @(posedge clk);
      check("sb.empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
